// File: rtl/gate_resp_checker.sv
// Self-checking responder for the 2-input gate lab set: walks a,b through 00..11,
// compares the five gate outputs with the truth table, holds a sticky summary.
// Optional first-failure log is built when GATE_CHK_ERR_LOG_EN is defined.
//
// state     | meaning
// IDLE      | waiting for start after reset
// DRIVE     | vector on a_out/b_out, settling for SETTLE_CYC cycles
// SAMPLE    | compare gate_res against expected for vec_idx
// DONE      | results frozen until next start

module gate_resp_checker #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [4:0] gate_res,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_mask,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx,
  output logic [1:0] first_fail_vec,
  output logic [4:0] first_fail_val,
  output logic       fail_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [4:0] expected;
  logic [4:0] mism;
  logic [1:0] vec_next;
  logic       start_go;

  // Truth table for {not, and2, or2, xor2, nand2} at (a,b) = vec_idx
  always_comb begin
    expected = {~vec_idx[1], &vec_idx, |vec_idx, ^vec_idx, ~(&vec_idx)};
    mism     = gate_res ^ expected;
    vec_next = vec_idx + 2'd1;
    start_go = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      vec_idx   <= 2'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_mask  <= 5'd0;
      err_count <= 3'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            state     <= ST_DRIVE;
            cnt       <= 4'd0;
            vec_idx   <= 2'd0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 5'd0;
            err_count <= 3'd0;
          end
        end
        ST_DRIVE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          err_mask <= err_mask | mism;
          if (|mism) err_count <= err_count + 3'd1;
          if (vec_idx == 2'd3) begin
            state <= ST_DONE;
            a_out <= 1'b0;
            b_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~|(err_mask | mism);
          end else begin
            state   <= ST_DRIVE;
            vec_idx <= vec_next;
            a_out   <= vec_next[1];
            b_out   <= vec_next[0];
            cnt     <= 4'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_CHK_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      first_fail_vec <= 2'd0;
      first_fail_val <= 5'd0;
      fail_valid     <= 1'b0;
    end else if ((state == ST_SAMPLE) && (|mism) && !fail_valid) begin
      first_fail_vec <= vec_idx;
      first_fail_val <= gate_res;
      fail_valid     <= 1'b1;
    end
  end
`else
  assign first_fail_vec = 2'd0;
  assign first_fail_val = 5'd0;
  assign fail_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: a gate model with selectable faults feeds
// gate_res; expected run results are queued at start and checked when done rises.

module tb_gate_resp_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       a_out, b_out;
  logic [4:0] gate_res;
  logic       busy, done, pass;
  logic [4:0] err_mask;
  logic [2:0] err_count;
  logic [1:0] vec_idx;
  logic [1:0] first_fail_vec;
  logic [4:0] first_fail_val;
  logic       fail_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mode     = 0;

  typedef struct {
    logic       pass;
    logic [4:0] mask;
    logic [2:0] count;
    logic       fvalid;
    logic [1:0] fvec;
    logic [4:0] fval;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  gate_resp_checker #(.SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out),
    .gate_res(gate_res), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_count(err_count), .vec_idx(vec_idx),
    .first_fail_vec(first_fail_vec), .first_fail_val(first_fail_val),
    .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Gate board model: 0 good, 1 and2 stuck-at-0, 2 xor2 wired as or2, 3 inverter inverted
  always_comb begin
    logic [4:0] g;
    g = {~a_out, a_out & b_out, a_out | b_out, a_out ^ b_out, ~(a_out & b_out)};
    case (mode)
      1: g[3] = 1'b0;
      2: g[1] = a_out | b_out;
      3: g[4] = ~g[4];
      default: ;
    endcase
    gate_res = g;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rising edge of done
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.done_cyc));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("err_mask", 32'(err_mask), 32'(e.mask));
        chk("err_count", 32'(err_count), 32'(e.count));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("ab_in_done", 32'({a_out, b_out}), 32'd0);
        chk("vec_idx_in_done", 32'(vec_idx), 32'd3);
`ifdef GATE_CHK_ERR_LOG_EN
        chk("fail_valid", 32'(fail_valid), 32'(e.fvalid));
        chk("first_fail_vec", 32'(first_fail_vec), 32'(e.fvec));
        chk("first_fail_val", 32'(first_fail_val), 32'(e.fval));
`else
        chk("log_tied_off", 32'({fail_valid, first_fail_vec, first_fail_val}), 32'd0);
`endif
      end
    end
    done_q = done;
  end

  // Hand-computed results per fault mode
  function automatic exp_t expect_for(input int m);
    exp_t e;
    case (m)
      1:       e = '{1'b0, 5'b01000, 3'd1, 1'b1, 2'd3, 5'b00100, 0};
      2:       e = '{1'b0, 5'b00010, 3'd1, 1'b1, 2'd3, 5'b01110, 0};
      3:       e = '{1'b0, 5'b10000, 3'd4, 1'b1, 2'd0, 5'b00001, 0};
      default: e = '{1'b1, 5'b00000, 3'd0, 1'b0, 2'd0, 5'b00000, 0};
    endcase
    return e;
  endfunction

  task automatic pulse_start(input bit expect_run);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    if (expect_run) begin
      e = expect_for(mode);
      e.done_cyc = cyc + 13;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_ab"}, 32'({a_out, b_out}), 32'd0);
    chk({tag, "_err_mask"}, 32'(err_mask), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_vec_idx"}, 32'(vec_idx), 32'd0);
    chk({tag, "_log"}, 32'({fail_valid, first_fail_vec, first_fail_val}), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Good gates, then each fault mode
    for (int m = 0; m < 4; m++) begin
      mode = m;
      pulse_start(1'b1);
      wait_done();
      @(negedge clk);
      chk("done_held", 32'(done), 32'd1);
    end

    // start re-pulsed mid-run is ignored: latency still counts from first start
    mode = 0;
    pulse_start(1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_run", 32'(busy), 32'd1);
    wait_done();

    // Reset during vector 2 discards the run
    mode = 1;
    pulse_start(1'b0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (vec_idx == 2'd2) begin
          hit = 1'b1;
          break;
        end
      end
      chk("reach_vec2", 32'(hit), 32'd1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrun_rst");
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", 32'(done), 32'd0);
    mode = 0;
    pulse_start(1'b1);
    wait_done();

    // Failing run, then restart from DONE with good gates
    mode = 2;
    pulse_start(1'b1);
    wait_done();
    mode = 0;
    pulse_start(1'b1);
    chk("restart_cleared_mask", 32'(err_mask), 32'd0);
    chk("restart_cleared_done", 32'({done, pass, busy}), 32'b001);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
